// File: rtl/pll_cal_pkg.sv
// Shared encodings and default parameters for the PLL calibration sequencer.
package pll_cal_pkg;

  localparam int CODE_W_DEF     = 8;
  localparam int LOCK_CNT_DEF   = 64;
  localparam int TIMEOUT_DEF    = 4096;
  localparam int UNLOCK_THR_DEF = 16;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE        = 3'd0,
    COARSE_REQ  = 3'd1,
    COARSE_WAIT = 3'd2,
    FINE        = 3'd3,
    LOCKED      = 3'd4,
    FAIL        = 3'd5
  } cal_state_t;

endpackage

// File: rtl/pll_cal_edge_sync.sv
// Brings an asynchronous PFD pulse into the clock domain and emits a one-cycle
// strobe on each synchronized rising edge.
module pll_cal_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);

  // [0],[1] form the synchronizer; [2] holds the previous synchronized value.
  logic [2:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 3'b000;
    end else begin
      sync_q <= {sync_q[1:0], d};
    end
  end

  assign pulse = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/pll_cal_ctrl.sv
// DCO calibration sequencer: SAR coarse search on PFD frequency flags, then
// up/down tracking with lock detection and automatic relock.
module pll_cal_ctrl
  import pll_cal_pkg::*;
#(
  parameter int CODE_W     = CODE_W_DEF,
  parameter int LOCK_CNT   = LOCK_CNT_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF,
  parameter int UNLOCK_THR = UNLOCK_THR_DEF
) (
  input  logic              ref_clk,
  input  logic              rst,
  input  logic              start,
  input  logic              freq_check_done,
  input  logic              ref_clk_is_faster,
  input  logic              ref_clk_is_slower,
  input  logic              up,
  input  logic              down,
  output logic              check_req,
  output logic [CODE_W-1:0] dco_code,
  output logic              busy,
  output logic              locked,
  output logic              cal_fail,
  output logic [STATE_W-1:0] state
);

  localparam int BIT_W   = (CODE_W > 1) ? $clog2(CODE_W) : 1;
  localparam int TMO_W   = $clog2(TIMEOUT);
  localparam int QUIET_W = $clog2(LOCK_CNT);
  localparam int MISS_W  = $clog2(UNLOCK_THR);

  localparam logic [CODE_W-1:0] CODE_MID = {1'b1, {(CODE_W-1){1'b0}}};
  localparam logic [CODE_W-1:0] CODE_MAX = {CODE_W{1'b1}};

  // Handshake: check_req is a one-cycle request; the PFD answers later with a
  // one-cycle freq_check_done carrying the faster/slower flags in that cycle.

  cal_state_t         cur;
  logic [BIT_W-1:0]   bit_idx;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [QUIET_W-1:0] quiet_cnt;
  logic [MISS_W-1:0]  miss_cnt;

  logic up_e, down_e;

  pll_cal_edge_sync u_sync_up (
    .clk   (ref_clk),
    .rst   (rst),
    .d     (up),
    .pulse (up_e)
  );

  pll_cal_edge_sync u_sync_down (
    .clk   (ref_clk),
    .rst   (rst),
    .d     (down),
    .pulse (down_e)
  );

  logic              step_up, step_dn, step, rail, quiet_done;
  logic              start_cal, relock;
  logic [CODE_W-1:0] bit_mask, coarse_kept;

  assign step_up    = up_e & ~down_e;
  assign step_dn    = down_e & ~up_e;
  assign step       = step_up | step_dn;
  assign rail       = (step_up && dco_code == CODE_MAX) || (step_dn && dco_code == '0);
  assign quiet_done = (quiet_cnt == QUIET_W'(LOCK_CNT - 1));

  assign start_cal = start && (cur == IDLE || cur == LOCKED || cur == FAIL);
  assign relock    = (cur == LOCKED) && step && !rail &&
                     (miss_cnt == MISS_W'(UNLOCK_THR - 1));

  assign bit_mask    = CODE_W'(1) << bit_idx;
  assign coarse_kept = ref_clk_is_slower ? (dco_code & ~bit_mask) : dco_code;

  always_ff @(posedge ref_clk or posedge rst) begin
    if (rst) begin
      cur       <= IDLE;
      dco_code  <= CODE_MID;
      bit_idx   <= '0;
      tmo_cnt   <= '0;
      quiet_cnt <= '0;
      miss_cnt  <= '0;
      check_req <= 1'b0;
      busy      <= 1'b0;
      locked    <= 1'b0;
      cal_fail  <= 1'b0;
    end else begin
      check_req <= 1'b0;
      if (start_cal || relock) begin
        cur       <= COARSE_REQ;
        dco_code  <= CODE_MID;
        bit_idx   <= BIT_W'(CODE_W - 1);
        tmo_cnt   <= '0;
        quiet_cnt <= '0;
        miss_cnt  <= '0;
        check_req <= 1'b1;
        busy      <= 1'b1;
        locked    <= 1'b0;
        cal_fail  <= 1'b0;
      end else begin
        case (cur)
          COARSE_REQ: begin
            cur     <= COARSE_WAIT;
            tmo_cnt <= '0;
          end
          COARSE_WAIT: begin
            if (freq_check_done) begin
              if (ref_clk_is_faster && ref_clk_is_slower) begin
                cur      <= FAIL;
                busy     <= 1'b0;
                cal_fail <= 1'b1;
              end else if (!ref_clk_is_faster && !ref_clk_is_slower) begin
                cur       <= FINE;
                quiet_cnt <= '0;
              end else if (bit_idx == '0) begin
                dco_code  <= coarse_kept;
                cur       <= FINE;
                quiet_cnt <= '0;
              end else begin
                dco_code  <= coarse_kept | (bit_mask >> 1);
                bit_idx   <= bit_idx - 1'b1;
                cur       <= COARSE_REQ;
                check_req <= 1'b1;
              end
            end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
              cur      <= FAIL;
              busy     <= 1'b0;
              cal_fail <= 1'b1;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end
          FINE, LOCKED: begin
            if (rail) begin
              cur      <= FAIL;
              busy     <= 1'b0;
              locked   <= 1'b0;
              cal_fail <= 1'b1;
            end else if (step) begin
              dco_code  <= step_up ? dco_code + 1'b1 : dco_code - 1'b1;
              quiet_cnt <= '0;
              if (cur == LOCKED) miss_cnt <= miss_cnt + 1'b1;
            end else if (quiet_done) begin
              // A full quiet window forgives earlier misses while locked.
              quiet_cnt <= '0;
              miss_cnt  <= '0;
              if (cur == FINE) begin
                cur    <= LOCKED;
                busy   <= 1'b0;
                locked <= 1'b1;
              end
            end else begin
              quiet_cnt <= quiet_cnt + 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_pll_cal_ctrl.sv
// Directed-plus-random bench for pll_cal_ctrl with a behavioural SAR/step model.
module tb_pll_cal_ctrl;

  localparam int W = 8;
  localparam int ST_IDLE = 0, ST_REQ = 1, ST_WAIT = 2, ST_FINE = 3, ST_LOCKED = 4, ST_FAIL = 5;

  logic         ref_clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         freq_check_done = 1'b0;
  logic         ref_clk_is_faster = 1'b0;
  logic         ref_clk_is_slower = 1'b0;
  logic         up = 1'b0;
  logic         down = 1'b0;
  logic         check_req;
  logic [W-1:0] dco_code;
  logic         busy;
  logic         locked;
  logic         cal_fail;
  logic [2:0]   state;

  pll_cal_ctrl dut (
    .ref_clk           (ref_clk),
    .rst               (rst),
    .start             (start),
    .freq_check_done   (freq_check_done),
    .ref_clk_is_faster (ref_clk_is_faster),
    .ref_clk_is_slower (ref_clk_is_slower),
    .up                (up),
    .down              (down),
    .check_req         (check_req),
    .dco_code          (dco_code),
    .busy              (busy),
    .locked            (locked),
    .cal_fail          (cal_fail),
    .state             (state)
  );

  always #5 ref_clk = ~ref_clk;

  int           n_vec = 0;
  int           n_err = 0;
  logic [W-1:0] exp_q[$];
  int           exp_code;

  task automatic tick();
    @(negedge ref_clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Successive-approximation probe list from the search rules; returns final code.
  function automatic int sar_model(input int target);
    int code;
    exp_q.delete();
    code = 1 << (W - 1);
    for (int b = W - 1; b >= 0; b--) begin
      exp_q.push_back(W'(code));
      if (code == target) break;
      if (code > target) code -= (1 << b);
      if (b > 0) code += (1 << (b - 1));
    end
    return code;
  endfunction

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // PFD stand-in: answers each request by comparing the probed code to target.
  task automatic run_coarse(input int target);
    int n;
    logic [W-1:0] probe;
    exp_code = sar_model(target);
    while (exp_q.size() > 0) begin
      n = 0;
      while (!check_req && n < 20) begin
        tick();
        n++;
      end
      chk("check_req_seen", check_req, 1);
      if (!check_req) begin
        exp_q.delete();
        return;
      end
      probe = exp_q.pop_front();
      chk("probe_code", dco_code, probe);
      tick();
      chk("check_req_one_cycle", check_req, 0);
      chk("wait_state", state, ST_WAIT);
      repeat ($urandom_range(0, 4)) tick();
      freq_check_done   = 1'b1;
      ref_clk_is_faster = (int'(probe) < target);
      ref_clk_is_slower = (int'(probe) > target);
      tick();
      freq_check_done   = 1'b0;
      ref_clk_is_faster = 1'b0;
      ref_clk_is_slower = 1'b0;
    end
    chk("fine_state", state, ST_FINE);
    chk("fine_code", dco_code, exp_code);
  endtask

  task automatic do_step(input bit dir_up, input int exp_new);
    int n;
    logic [W-1:0] old;
    repeat (3) tick();
    old = dco_code;
    if (dir_up) up = 1'b1; else down = 1'b1;
    n = 0;
    while (dco_code === old && n < 10) begin
      tick();
      n++;
    end
    up = 1'b0;
    down = 1'b0;
    chk("step_code", dco_code, exp_new);
  endtask

  task automatic rail_step(input bit dir_up, input int held);
    int n;
    repeat (3) tick();
    if (dir_up) up = 1'b1; else down = 1'b1;
    n = 0;
    while (!cal_fail && n < 10) begin
      tick();
      n++;
    end
    up = 1'b0;
    down = 1'b0;
    chk("rail_state", state, ST_FAIL);
    chk("rail_cal_fail", cal_fail, 1);
    chk("rail_code_held", dco_code, held);
  endtask

  task automatic wait_lock();
    int n;
    n = 0;
    while (!locked && n < 200) begin
      tick();
      n++;
    end
    chk("lock_delay", n, 64);
    chk("lock_state", state, ST_LOCKED);
    chk("lock_busy", busy, 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_state"}, state, ST_IDLE);
    chk({tag, "_code"}, dco_code, 8'h80);
    chk({tag, "_check_req"}, check_req, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_cal_fail"}, cal_fail, 0);
  endtask

  initial begin
    int n;
    int t;
    int k;
    bit dir;

    repeat (3) tick();
    chk_reset_outputs("reset");
    rst = 1'b0;
    tick();
    chk("idle_hold", state, ST_IDLE);

    // Always-faster search ends at all-ones; start while busy is ignored.
    do_start();
    chk("start_latency", check_req, 1);
    run_coarse(256);
    chk("fine_busy", busy, 1);
    chk("fine_locked", locked, 0);
    do_start();
    chk("busy_start_ignored", state, ST_FINE);
    chk("busy_start_no_req", check_req, 0);
    chk("busy_start_code", dco_code, 8'hFF);
    rail_step(1'b1, 8'hFF);

    // Target 0x5A, simultaneous up/down, then three ups to lock.
    do_start();
    run_coarse(8'h5A);
    repeat (3) tick();
    up = 1'b1;
    down = 1'b1;
    repeat (8) tick();
    up = 1'b0;
    down = 1'b0;
    chk("both_no_step", dco_code, 8'h5A);
    exp_code = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      exp_code++;
      do_step(1'b1, exp_code);
    end
    wait_lock();
    chk("lock_code", dco_code, 8'h5D);

    // Sixteen closely spaced misses force recalibration.
    for (int i = 0; i < 15; i++) begin
      exp_code--;
      do_step(1'b0, exp_code);
      chk("still_locked", locked, 1);
    end
    repeat (3) tick();
    down = 1'b1;
    n = 0;
    while (locked && n < 10) begin
      tick();
      n++;
    end
    down = 1'b0;
    chk("relock_locked", locked, 0);
    chk("relock_busy", busy, 1);
    chk("relock_check_req", check_req, 1);
    chk("relock_code", dco_code, 8'h80);

    // Random target, random tracking steps, lock again.
    t = $urandom_range(40, 215);
    run_coarse(t);
    k = $urandom_range(1, 6);
    for (int i = 0; i < k; i++) begin
      dir = 1'($urandom_range(0, 1));
      exp_code = dir ? exp_code + 1 : exp_code - 1;
      do_step(dir, exp_code);
    end
    wait_lock();
    chk("rand_lock_code", dco_code, exp_code);

    for (int i = 0; i < 3; i++) begin
      do_start();
      chk("locked_start_req", check_req, 1);
      run_coarse($urandom_range(0, 255));
      wait_lock();
    end

    // Unanswered request times out; restart begins from mid-scale.
    do_start();
    chk("force_cal_code", dco_code, 8'h80);
    tick();
    chk("timeout_wait_state", state, ST_WAIT);
    n = 0;
    while (!cal_fail && n < 5000) begin
      tick();
      n++;
    end
    chk("timeout_cycles", n, 4096);
    chk("timeout_state", state, ST_FAIL);
    chk("timeout_code", dco_code, 8'h80);
    chk("timeout_busy", busy, 0);
    do_start();
    chk("restart_req", check_req, 1);
    chk("restart_code", dco_code, 8'h80);

    // Always-slower search ends at zero; a down step there fails.
    run_coarse(-1);
    rail_step(1'b0, 8'h00);

    // Contradictory frequency flags.
    do_start();
    tick();
    freq_check_done   = 1'b1;
    ref_clk_is_faster = 1'b1;
    ref_clk_is_slower = 1'b1;
    tick();
    freq_check_done   = 1'b0;
    ref_clk_is_faster = 1'b0;
    ref_clk_is_slower = 1'b0;
    chk("both_flags_state", state, ST_FAIL);
    chk("both_flags_cal_fail", cal_fail, 1);

    // Reset in the middle of a coarse wait.
    do_start();
    tick();
    freq_check_done   = 1'b1;
    ref_clk_is_faster = 1'b1;
    tick();
    freq_check_done   = 1'b0;
    ref_clk_is_faster = 1'b0;
    chk("pre_reset_code", dco_code, 8'hC0);
    tick();
    tick();
    chk("pre_reset_state", state, ST_WAIT);
    rst = 1'b1;
    #1;
    chk_reset_outputs("async_reset");
    tick();
    rst = 1'b0;
    tick();
    chk("post_reset_idle", state, ST_IDLE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
